// File: rtl/piso_stream.sv
`default_nettype none
// ============================================================================
// Module      : piso_stream
// Description : Parallel-in / serial-out streaming serialiser. A DATA_W shift
//               register with a bit counter is backed by a one-entry holding
//               buffer so consecutive words stream with no idle cycle.
//               Optional feature macro: PISO_STREAM_PARITY_EN appends one
//               even-parity bit after the last data bit of every word.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_stream #(
  parameter int DATA_W    = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] parallel_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              serial_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic              empty_o
);

  localparam int c_CNT_W = $clog2(DATA_W + 1);
`ifdef PISO_STREAM_PARITY_EN
  localparam int c_NBITS = DATA_W + 1;
`else
  localparam int c_NBITS = DATA_W;
`endif
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NBITS - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_full;
  logic [c_CNT_W-1:0] r_cnt;

  logic              w_accept;
  logic              w_consume;
  logic              w_at_last;
  logic              w_done;
  logic              w_load;
  logic              w_to_hold;
  logic              w_data_bit;
  logic              w_bit;
  logic [DATA_W-1:0] w_shift_nxt;

  assign w_accept  = valid_i & ready_o;
  assign w_consume = valid_o & ready_i;
  assign w_at_last = (r_cnt == c_LAST);
  assign w_done    = w_consume & w_at_last;
  // The shifter is (re)loaded when it is empty and a word arrives, or when its
  // last bit leaves and something is waiting (buffered word or a new accept).
  assign w_load    = ((r_state == S_IDLE) & w_accept) | (w_done & (r_hold_full | w_accept));
  // An accepted word goes straight to the shifter only if the shifter is loaded
  // from parallel_i this cycle; otherwise it lands in the holding buffer.
  assign w_to_hold = w_accept & ~(w_load & ~r_hold_full);

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_data_bit  = r_shift[DATA_W-1];
      assign w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_data_bit  = r_shift[0];
      assign w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
    end
  endgenerate

`ifdef PISO_STREAM_PARITY_EN
  logic r_par;
  logic r_hold_par;

  // Parity travels alongside each word so the shifter and buffer stay in step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_par      <= 1'b0;
      r_hold_par <= 1'b0;
    end else begin
      if (w_load) begin
        r_par <= r_hold_full ? r_hold_par : ^parallel_i;
      end
      if (w_to_hold) begin
        r_hold_par <= ^parallel_i;
      end
    end
  end

  assign w_bit = (r_cnt == c_CNT_W'(DATA_W)) ? r_par : w_data_bit;
`else
  assign w_bit = w_data_bit;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: leave SHIFT only when nothing follows the final bit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_done && !r_hold_full && !w_accept) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    valid_o  = (r_state == S_SHIFT);
    last_o   = valid_o & w_at_last;
    serial_o = valid_o & w_bit;
    ready_o  = ~r_hold_full;
    empty_o  = (r_state == S_IDLE) & ~r_hold_full;
  end

  // Shifter, counter and holding buffer; the shifter freezes while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_load) begin
        r_shift <= r_hold_full ? r_hold : parallel_i;
        r_cnt   <= '0;
      end else if (w_consume) begin
        r_shift <= w_shift_nxt;
        r_cnt   <= w_at_last ? '0 : r_cnt + 1'b1;
      end

      if (w_to_hold) begin
        r_hold      <= parallel_i;
        r_hold_full <= 1'b1;
      end else if (w_load && r_hold_full) begin
        r_hold_full <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_stream
// Description : Scoreboard bench for piso_stream; one LSB-first and one
//               MSB-first instance share clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_stream;

`ifdef PISO_STREAM_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] p0, p1;
  logic       v0, v1, ri0, ri1;
  logic       rdy0, ser0, vo0, last0, emp0;
  logic       rdy1, ser1, vo1, last1, emp1;

  int checks = 0;
  int errors = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];

  int   vcnt1, vrise1, rlow1;
  logic pv1;
  logic win1 = 1'b0;

  always #5 clk = ~clk;

  piso_stream #(.DATA_W(8), .MSB_FIRST(0)) u0 (
    .clk(clk), .reset(reset), .parallel_i(p0), .valid_i(v0), .ready_o(rdy0),
    .serial_o(ser0), .valid_o(vo0), .ready_i(ri0), .last_o(last0), .empty_o(emp0)
  );

  piso_stream #(.DATA_W(8), .MSB_FIRST(1)) u1 (
    .clk(clk), .reset(reset), .parallel_i(p1), .valid_i(v1), .ready_o(rdy1),
    .serial_o(ser1), .valid_o(vo1), .ready_i(ri1), .last_o(last1), .empty_o(emp1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {serial, last} stream of one word, in order.
  task automatic push_word(input int which, input logic [7:0] w);
    logic [1:0] e;
    for (int i = 0; i < NB; i++) begin
      if (i < 8) e[1] = (which == 1) ? w[7-i] : w[i];
      else       e[1] = ^w;
      e[0] = (i == NB - 1);
      if (which == 0) q0.push_back(e);
      else            q1.push_back(e);
    end
  endtask

  task automatic wait_idle(input int which);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (which == 0 && emp0 && q0.size() == 0) begin ok = 1'b1; break; end
      if (which == 1 && emp1 && q1.size() == 0) begin ok = 1'b1; break; end
    end
    chk($sformatf("u%0d drained", which), {31'd0, ok}, 32'd1);
  endtask

  // Monitor: every consumed bit is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!reset && vo0 && ri0) begin
      if (q0.size() == 0) chk("u0 bit without word", {31'd0, vo0}, 32'd0);
      else begin
        logic [1:0] e;
        e = q0.pop_front();
        chk("u0 serial", {31'd0, ser0}, {31'd0, e[1]});
        chk("u0 last", {31'd0, last0}, {31'd0, e[0]});
      end
    end
    if (!reset && vo1 && ri1) begin
      if (q1.size() == 0) chk("u1 bit without word", {31'd0, vo1}, 32'd0);
      else begin
        logic [1:0] e;
        e = q1.pop_front();
        chk("u1 serial", {31'd0, ser1}, {31'd0, e[1]});
        chk("u1 last", {31'd0, last1}, {31'd0, e[0]});
      end
    end
    if (win1) begin
      if (vo1) vcnt1++;
      if (vo1 && !pv1) vrise1++;
      if (!rdy1) rlow1++;
      pv1 = vo1;
    end
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    p0 = '0; p1 = '0; v0 = 1'b0; v1 = 1'b0; ri0 = 1'b1; ri1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst u0 valid", {31'd0, vo0}, 32'd0);
    chk("rst u0 last", {31'd0, last0}, 32'd0);
    chk("rst u0 serial", {31'd0, ser0}, 32'd0);
    chk("rst u0 ready", {31'd0, rdy0}, 32'd1);
    chk("rst u0 empty", {31'd0, emp0}, 32'd1);
    chk("rst u1 valid", {31'd0, vo1}, 32'd0);
    chk("rst u1 ready", {31'd0, rdy1}, 32'd1);
    chk("rst u1 empty", {31'd0, emp1}, 32'd1);

    // LSB-first 0xA5: valid on cycles 1..NB after accept, then empty
    p0 = 8'hA5; v0 = 1'b1; push_word(0, 8'hA5);
    @(posedge clk); #1 v0 = 1'b0;
    for (int k = 1; k <= NB; k++) begin
      @(negedge clk);
      chk($sformatf("t1 valid cycle %0d", k), {31'd0, vo0}, 32'd1);
    end
    @(negedge clk);
    chk("t1 valid after word", {31'd0, vo0}, 32'd0);
    chk("t1 empty after word", {31'd0, emp0}, 32'd1);

    // MSB-first 0x81 then 0x3C, contiguous
    p1 = 8'h81; v1 = 1'b1; push_word(1, 8'h81);
    @(posedge clk); #1 v1 = 1'b0;
    vcnt1 = 0; vrise1 = 0; rlow1 = 0; pv1 = 1'b0; win1 = 1'b1;
    repeat (NB - 2) @(posedge clk);
    #1 p1 = 8'h3C; v1 = 1'b1; push_word(1, 8'h3C);
    @(posedge clk); #1 v1 = 1'b0;
    wait_idle(1);
    win1 = 1'b0;
    chk("t2 valid bit count", vcnt1, 2 * NB);
    chk("t2 valid bursts", vrise1, 32'd1);
    chk("t2 ready low cycles", rlow1, 32'd1);

    // LSB-first 0xF0 with 3-cycle stall after bit 2
    @(negedge clk);
    p0 = 8'hF0; v0 = 1'b1; push_word(0, 8'hF0);
    @(posedge clk); #1 v0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 ri0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3 stall valid", {31'd0, vo0}, 32'd1);
      chk("t3 stall serial", {31'd0, ser0}, 32'd0);
      chk("t3 stall last", {31'd0, last0}, 32'd0);
    end
    @(posedge clk); #1 ri0 = 1'b1;
    repeat (NB - 4) @(posedge clk);
    @(negedge clk);
    chk("t3 late last valid", {31'd0, vo0}, 32'd1);
    chk("t3 late last flag", {31'd0, last0}, 32'd1);
    @(negedge clk);
    chk("t3 done valid", {31'd0, vo0}, 32'd0);
    chk("t3 scoreboard empty", q0.size(), 32'd0);

    // Reset mid-word with a word buffered
    p0 = 8'h5A; v0 = 1'b1; push_word(0, 8'h5A);
    @(posedge clk); #1 p0 = 8'h77; push_word(0, 8'h77);
    @(posedge clk); #1 v0 = 1'b0;
    @(negedge clk);
    chk("t4 buffered ready", {31'd0, rdy0}, 32'd0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    q0.delete();
    @(negedge clk);
    chk("t4 valid after reset", {31'd0, vo0}, 32'd0);
    chk("t4 empty after reset", {31'd0, emp0}, 32'd1);
    chk("t4 ready after reset", {31'd0, rdy0}, 32'd1);
    chk("t4 last after reset", {31'd0, last0}, 32'd0);
    p0 = 8'h01; v0 = 1'b1; push_word(0, 8'h01);
    @(posedge clk); #1 v0 = 1'b0;
    wait_idle(0);

`ifdef PISO_STREAM_PARITY_EN
    // Parity: 0x07 -> parity 1, 0x03 -> parity 0
    p0 = 8'h07; v0 = 1'b1; push_word(0, 8'h07);
    @(posedge clk); #1 p0 = 8'h03; push_word(0, 8'h03);
    @(posedge clk); #1 v0 = 1'b0;
    wait_idle(0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
